// File: rtl/fprint_comparator_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fprint_comparator_ctrl_pkg
//   Shared CRC/fingerprint dimensions used by the comparator controller and
//   its helpers, plus a pointer-increment helper that wraps modulo the
//   fingerprint RAM depth.
// ---------------------------------------------------------------------------
package fprint_comparator_ctrl_pkg;

  localparam int CRC_WIDTH             = 32;  // fingerprint width
  localparam int CRC_KEY_SIZE          = 16;  // number of tasks
  localparam int CRC_KEY_WIDTH         = 4;   // task index width
  localparam int CRC_RAM_SIZE          = 8;   // fingerprint RAM depth per core
  localparam int CRC_RAM_ADDRESS_WIDTH = 3;   // fingerprint RAM address width

  // Next pointer value, wrapping at CRC_RAM_SIZE (the depth need not be a
  // power of two).
  function automatic logic [CRC_RAM_ADDRESS_WIDTH-1:0] ptr_inc(
    input logic [CRC_RAM_ADDRESS_WIDTH-1:0] p
  );
    if (p == CRC_RAM_ADDRESS_WIDTH'(CRC_RAM_SIZE - 1)) begin
      return '0;
    end
    return p + CRC_RAM_ADDRESS_WIDTH'(1);
  endfunction

endpackage

// File: rtl/fprint_task_prio_enc.sv
// ---------------------------------------------------------------------------
// fprint_task_prio_enc
//   Lowest-set-bit priority encoder over the per-task check-in vector.
//   Ports:
//     req   in  CRC_KEY_SIZE   one bit per task
//     idx   out CRC_KEY_WIDTH  index of the lowest set bit (0 when none)
//     valid out 1              at least one bit of req is set
// ---------------------------------------------------------------------------
module fprint_task_prio_enc
  import fprint_comparator_ctrl_pkg::*;
(
  input  logic [CRC_KEY_SIZE-1:0]  req,
  output logic [CRC_KEY_WIDTH-1:0] idx,
  output logic                     valid
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    idx = '0;
    for (int i = CRC_KEY_SIZE - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = CRC_KEY_WIDTH'(i);
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/fprint_comparator_ctrl.sv
// ---------------------------------------------------------------------------
// fprint_comparator_ctrl
//   Tracks per-core fingerprint head pointers and a shared tail pointer,
//   compares the two cores' fingerprints entry by entry, and hands verified
//   (or faulted) tasks back to the check-in register for clearing.
//   Ports:
//     clk, reset               clock, asynchronous active-high reset
//     increment_head_pointer   request to advance hp[logical_core_id]
//     logical_core_id          core owning the request / head pointer mux
//     increment_hp_ack         one-cycle grant of an increment
//     fprint_head_pointer      head pointer of logical_core_id
//     comp_tail_pointer0/1     shared compare read address (tail pointer)
//     fprint0/1                RAM read data, one cycle after the address
//     checkin_reg_out          per-task "both cores checked in" bits
//     comp_task_verified/comp_task  clear request for a task, held to ack
//     fprint_reg_ack           acknowledge of the clear request
//     mismatch/mismatch_task   sticky fault flag and first faulting task
//     mismatch_clear           clears the fault flag and task
// ---------------------------------------------------------------------------
module fprint_comparator_ctrl
  import fprint_comparator_ctrl_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             increment_head_pointer,
  input  logic                             logical_core_id,
  output logic                             increment_hp_ack,
  output logic [CRC_RAM_ADDRESS_WIDTH-1:0] fprint_head_pointer,
  output logic [CRC_RAM_ADDRESS_WIDTH-1:0] comp_tail_pointer0,
  output logic [CRC_RAM_ADDRESS_WIDTH-1:0] comp_tail_pointer1,
  input  logic [CRC_WIDTH-1:0]             fprint0,
  input  logic [CRC_WIDTH-1:0]             fprint1,
  input  logic [CRC_KEY_SIZE-1:0]          checkin_reg_out,
  output logic                             comp_task_verified,
  output logic [CRC_KEY_WIDTH-1:0]         comp_task,
  input  logic                             fprint_reg_ack,
  output logic                             mismatch,
  output logic [CRC_KEY_WIDTH-1:0]         mismatch_task,
  input  logic                             mismatch_clear
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_COMPARE,
    ST_VERIFY,
    ST_FAULT
  } state_t;

  state_t                           state_q, state_d;
  logic [CRC_RAM_ADDRESS_WIDTH-1:0] hp0_q, hp0_d;
  logic [CRC_RAM_ADDRESS_WIDTH-1:0] hp1_q, hp1_d;
  logic [CRC_RAM_ADDRESS_WIDTH-1:0] tp_q, tp_d;
  logic                             ack_q, ack_d;
  logic                             inc_done_q, inc_done_d;
  logic [CRC_KEY_WIDTH-1:0]         comp_task_q, comp_task_d;
  logic                             mismatch_q, mismatch_d;
  logic [CRC_KEY_WIDTH-1:0]         mismatch_task_q, mismatch_task_d;

  logic [CRC_KEY_WIDTH-1:0]         enc_idx;
  logic                             enc_valid;
  logic [CRC_RAM_ADDRESS_WIDTH-1:0] sel_hp;
  logic                             full;
  logic                             grant;
  logic                             fault_entry;
  logic [CRC_KEY_WIDTH-1:0]         fault_task;

  fprint_task_prio_enc u_prio_enc (
    .req   (checkin_reg_out),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  assign sel_hp = logical_core_id ? hp1_q : hp0_q;
  // Advancing onto the tail would make a full buffer look empty.
  assign full   = (ptr_inc(sel_hp) == tp_q);
  // A fault reports the lowest checked-in task if any, else the last task.
  assign fault_task = enc_valid ? enc_idx : comp_task_q;

  always_comb begin
    state_d         = state_q;
    hp0_d           = hp0_q;
    hp1_d           = hp1_q;
    tp_d            = tp_q;
    ack_d           = 1'b0;
    comp_task_d     = comp_task_q;
    mismatch_d      = mismatch_q;
    mismatch_task_d = mismatch_task_q;
    fault_entry     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if ((hp0_q != tp_q) && (hp1_q != tp_q)) begin
          state_d = ST_READ;
        end else if (enc_valid) begin
          if (hp0_q != hp1_q) begin
            state_d     = ST_FAULT;
            fault_entry = 1'b1;
          end else begin
            state_d     = ST_VERIFY;
            comp_task_d = enc_idx;
          end
        end
      end
      ST_READ: begin
        state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        if (fprint0 == fprint1) begin
          tp_d    = ptr_inc(tp_q);
          state_d = ST_IDLE;
        end else begin
          state_d     = ST_FAULT;
          fault_entry = 1'b1;
        end
      end
      ST_VERIFY, ST_FAULT: begin
        if (fprint_reg_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Increments run alongside the FSM. One grant per request assertion;
    // a discard cycle suppresses the grant so it cannot be lost silently.
    grant = increment_head_pointer && !inc_done_q && !full && !fault_entry;
    inc_done_d = increment_head_pointer && (inc_done_q || grant);
    if (grant) begin
      ack_d = 1'b1;
      if (logical_core_id) begin
        hp1_d = ptr_inc(hp1_q);
      end else begin
        hp0_d = ptr_inc(hp0_q);
      end
    end

    if (fault_entry) begin
      // Discard all outstanding fingerprints of both cores.
      hp0_d       = '0;
      hp1_d       = '0;
      tp_d        = '0;
      comp_task_d = fault_task;
      mismatch_d  = 1'b1;
      // Keep the first fault's task unless it is being cleared right now.
      if (!mismatch_q || mismatch_clear) begin
        mismatch_task_d = fault_task;
      end
    end else if (mismatch_clear) begin
      mismatch_d      = 1'b0;
      mismatch_task_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      hp0_q           <= '0;
      hp1_q           <= '0;
      tp_q            <= '0;
      ack_q           <= 1'b0;
      inc_done_q      <= 1'b0;
      comp_task_q     <= '0;
      mismatch_q      <= 1'b0;
      mismatch_task_q <= '0;
    end else begin
      state_q         <= state_d;
      hp0_q           <= hp0_d;
      hp1_q           <= hp1_d;
      tp_q            <= tp_d;
      ack_q           <= ack_d;
      inc_done_q      <= inc_done_d;
      comp_task_q     <= comp_task_d;
      mismatch_q      <= mismatch_d;
      mismatch_task_q <= mismatch_task_d;
    end
  end

  assign increment_hp_ack    = ack_q;
  assign fprint_head_pointer = sel_hp;
  assign comp_tail_pointer0  = tp_q;
  assign comp_tail_pointer1  = tp_q;
  assign comp_task_verified  = (state_q == ST_VERIFY) || (state_q == ST_FAULT);
  assign comp_task           = comp_task_q;
  assign mismatch            = mismatch_q;
  assign mismatch_task       = mismatch_task_q;

endmodule

// File: tb/tb_fprint_comparator_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fprint_comparator_ctrl
//   Directed bench for fprint_comparator_ctrl: increment/ack handshake,
//   compare, verify, fault/discard, full-buffer back-pressure and reset.
// ---------------------------------------------------------------------------
module tb_fprint_comparator_ctrl;
  import fprint_comparator_ctrl_pkg::*;

  logic                             clk;
  logic                             reset;
  logic                             increment_head_pointer;
  logic                             logical_core_id;
  logic                             increment_hp_ack;
  logic [CRC_RAM_ADDRESS_WIDTH-1:0] fprint_head_pointer;
  logic [CRC_RAM_ADDRESS_WIDTH-1:0] comp_tail_pointer0;
  logic [CRC_RAM_ADDRESS_WIDTH-1:0] comp_tail_pointer1;
  logic [CRC_WIDTH-1:0]             fprint0;
  logic [CRC_WIDTH-1:0]             fprint1;
  logic [CRC_KEY_SIZE-1:0]          checkin_reg_out;
  logic                             comp_task_verified;
  logic [CRC_KEY_WIDTH-1:0]         comp_task;
  logic                             fprint_reg_ack;
  logic                             mismatch;
  logic [CRC_KEY_WIDTH-1:0]         mismatch_task;
  logic                             mismatch_clear;

  int n_checks = 0;
  int n_errors = 0;

  fprint_comparator_ctrl dut (
    .clk                    (clk),
    .reset                  (reset),
    .increment_head_pointer (increment_head_pointer),
    .logical_core_id        (logical_core_id),
    .increment_hp_ack       (increment_hp_ack),
    .fprint_head_pointer    (fprint_head_pointer),
    .comp_tail_pointer0     (comp_tail_pointer0),
    .comp_tail_pointer1     (comp_tail_pointer1),
    .fprint0                (fprint0),
    .fprint1                (fprint1),
    .checkin_reg_out        (checkin_reg_out),
    .comp_task_verified     (comp_task_verified),
    .comp_task              (comp_task),
    .fprint_reg_ack         (fprint_reg_ack),
    .mismatch               (mismatch),
    .mismatch_task          (mismatch_task),
    .mismatch_clear         (mismatch_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    increment_head_pointer = 1'b0;
    checkin_reg_out = '0;
    fprint_reg_ack = 1'b0;
    mismatch_clear = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // One full request/ack handshake; an ack that never comes is a failure.
  task automatic inc_once(input logic core, input string tag);
    int seen;
    seen = 0;
    logical_core_id = core;
    increment_head_pointer = 1'b1;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      tick();
      if (increment_hp_ack) seen = 1;
    end
    check(tag, 64'(seen), 64'd1);
    increment_head_pointer = 1'b0;
    tick();
  endtask

  task automatic head_ptr(input logic core, output logic [CRC_RAM_ADDRESS_WIDTH-1:0] v);
    logical_core_id = core;
    #1;
    v = fprint_head_pointer;
  endtask

  task automatic wait_tp(input logic [CRC_RAM_ADDRESS_WIDTH-1:0] val, input string tag);
    for (int i = 0; i < 30 && comp_tail_pointer0 != val; i++) tick();
    check(tag, 64'(comp_tail_pointer0), 64'(val));
  endtask

  task automatic wait_verified(input string tag);
    for (int i = 0; i < 30 && !comp_task_verified; i++) tick();
    check(tag, 64'(comp_task_verified), 64'd1);
  endtask

  task automatic ack_clear();
    fprint_reg_ack = 1'b1;
    checkin_reg_out = '0;
    tick();
    fprint_reg_ack = 1'b0;
  endtask

  logic [CRC_RAM_ADDRESS_WIDTH-1:0] hp;
  int acks;

  initial begin
    reset = 1'b1;
    increment_head_pointer = 1'b0;
    logical_core_id = 1'b0;
    fprint0 = 32'hDEADBEEF;
    fprint1 = 32'hDEADBEEF;
    checkin_reg_out = '0;
    fprint_reg_ack = 1'b0;
    mismatch_clear = 1'b0;
    #3;
    check("rst_ack", 64'(increment_hp_ack), 64'd0);
    check("rst_verified", 64'(comp_task_verified), 64'd0);
    check("rst_tp", 64'(comp_tail_pointer0), 64'd0);
    check("rst_mismatch", 64'(mismatch), 64'd0);
    do_reset();

    // Matching fingerprints, then verify task 2.
    for (int k = 0; k < 3; k++) begin
      inc_once(1'b0, "m_inc0");
      inc_once(1'b1, "m_inc1");
    end
    wait_tp(3'd3, "m_tp3");
    check("m_tp1_same", 64'(comp_tail_pointer1), 64'd3);
    checkin_reg_out = 16'h0004;
    wait_verified("m_verified");
    check("m_comp_task", 64'(comp_task), 64'd2);
    tick(); tick(); tick();
    check("m_verified_held", 64'(comp_task_verified), 64'd1);
    ack_clear();
    check("m_verified_drop", 64'(comp_task_verified), 64'd0);
    check("m_mismatch", 64'(mismatch), 64'd0);

    // Differing fingerprints -> fault and discard.
    do_reset();
    fprint0 = 32'h1;
    fprint1 = 32'h2;
    inc_once(1'b0, "f_inc0");
    inc_once(1'b1, "f_inc1");
    wait_verified("f_verified");
    check("f_mismatch", 64'(mismatch), 64'd1);
    check("f_tp", 64'(comp_tail_pointer0), 64'd0);
    head_ptr(1'b0, hp);
    check("f_hp0", 64'(hp), 64'd0);
    head_ptr(1'b1, hp);
    check("f_hp1", 64'(hp), 64'd0);
    ack_clear();
    check("f_verified_drop", 64'(comp_task_verified), 64'd0);
    check("f_mismatch_hold", 64'(mismatch), 64'd1);
    mismatch_clear = 1'b1;
    tick();
    mismatch_clear = 1'b0;
    check("f_mismatch_clr", 64'(mismatch), 64'd0);
    fprint0 = 32'hDEADBEEF;
    fprint1 = 32'hDEADBEEF;

    // Full buffer: the last core-0 increment is held off.
    do_reset();
    for (int k = 0; k < CRC_RAM_SIZE - 1; k++) inc_once(1'b0, "full_inc0");
    logical_core_id = 1'b0;
    increment_head_pointer = 1'b1;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (increment_hp_ack) acks++;
    end
    check("full_withheld", 64'(acks), 64'd0);
    check("full_hp0", 64'(fprint_head_pointer), 64'(CRC_RAM_SIZE - 1));
    increment_head_pointer = 1'b0;
    tick();
    inc_once(1'b1, "full_inc1");
    wait_tp(3'd1, "full_tp1");
    inc_once(1'b0, "full_release");
    head_ptr(1'b0, hp);
    check("full_hp0_wrap", 64'(hp), 64'd0);

    // Unequal counts at verify time -> fault on task 0.
    do_reset();
    inc_once(1'b0, "u_inc0a");
    inc_once(1'b0, "u_inc0b");
    inc_once(1'b1, "u_inc1");
    wait_tp(3'd1, "u_tp1");
    checkin_reg_out = 16'h0001;
    wait_verified("u_verified");
    check("u_mismatch", 64'(mismatch), 64'd1);
    check("u_mismatch_task", 64'(mismatch_task), 64'd0);
    check("u_tp", 64'(comp_tail_pointer0), 64'd0);
    ack_clear();

    // First fault's task is kept while mismatch stays set.
    do_reset();
    inc_once(1'b0, "s_inc0a");
    checkin_reg_out = 16'h0008;
    wait_verified("s_verified_a");
    check("s_task_a", 64'(mismatch_task), 64'd3);
    check("s_comp_task_a", 64'(comp_task), 64'd3);
    ack_clear();
    inc_once(1'b0, "s_inc0b");
    checkin_reg_out = 16'h0001;
    wait_verified("s_verified_b");
    check("s_comp_task_b", 64'(comp_task), 64'd0);
    check("s_task_sticky", 64'(mismatch_task), 64'd3);
    ack_clear();
    mismatch_clear = 1'b1;
    tick();
    mismatch_clear = 1'b0;
    check("s_task_clr", 64'(mismatch_task), 64'd0);

    // Reset in the middle of a verify.
    do_reset();
    inc_once(1'b0, "r_inc0");
    inc_once(1'b1, "r_inc1");
    wait_tp(3'd1, "r_tp1");
    checkin_reg_out = 16'h0002;
    wait_verified("r_verified");
    #2;
    reset = 1'b1;
    #1;
    check("r_async_verified", 64'(comp_task_verified), 64'd0);
    check("r_async_task", 64'(comp_task), 64'd0);
    check("r_async_tp", 64'(comp_tail_pointer0), 64'd0);
    check("r_async_hp", 64'(fprint_head_pointer), 64'd0);
    tick();
    checkin_reg_out = '0;
    reset = 1'b0;
    tick(); tick(); tick();
    check("r_recover", 64'(comp_task_verified), 64'd0);

    // High task index and a long-held request.
    do_reset();
    checkin_reg_out = 16'h0A00;
    wait_verified("h_verified");
    check("h_comp_task", 64'(comp_task), 64'd9);
    ack_clear();
    logical_core_id = 1'b0;
    increment_head_pointer = 1'b1;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (increment_hp_ack) acks++;
    end
    increment_head_pointer = 1'b0;
    tick();
    check("h_one_ack", 64'(acks), 64'd1);
    check("h_hp0", 64'(fprint_head_pointer), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fprint_comparator_ctrl.md
FPRINT_COMPARATOR_CTRL -- requirements
Module: fprint_comparator_ctrl

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have increment_head_pointer, input, 1, request to advance the head pointer of core logical_core_id.
REQ-004 SHALL have logical_core_id, input, 1, logical core (0/1) owning the current increment request.
REQ-005 SHALL have increment_hp_ack, output, 1, one-cycle acknowledge of a granted increment.
REQ-006 SHALL have fprint_head_pointer, output, CRC_RAM_ADDRESS_WIDTH, head pointer of core logical_core_id (combinational mux).
REQ-007 SHALL have comp_tail_pointer0 / comp_tail_pointer1, output, CRC_RAM_ADDRESS_WIDTH each, shared compare read address (both carry the same value).
REQ-008 SHALL have fprint0 / fprint1, input, CRC_WIDTH each, RAM read data of cores 0/1, valid one cycle after the address.
REQ-009 SHALL have checkin_reg_out, input, CRC_KEY_SIZE, per-task bit: both cores checked in.
REQ-010 SHALL have comp_task_verified, output, 1, request to clear task comp_task's check-in/out state; held until ack.
REQ-011 SHALL have comp_task, output, CRC_KEY_WIDTH, task index qualified by comp_task_verified.
REQ-012 SHALL have fprint_reg_ack, input, 1, acknowledge of comp_task_verified.
REQ-013 SHALL have mismatch, output, 1, sticky fault flag; mismatch_task, output, CRC_KEY_WIDTH, task of first fault; mismatch_clear, input, 1, clears both.

Function
REQ-014 Head pointers hp0/hp1 and tail pointer tp SHALL be CRC_RAM_ADDRESS_WIDTH counters wrapping modulo CRC_RAM_SIZE.
REQ-015 Increment: in the cycle after increment_head_pointer is seen, hp[logical_core_id] SHALL advance by 1 and increment_hp_ack SHALL pulse for exactly one cycle; a request held through the ack SHALL NOT double-increment (ack not re-issued until the request deasserts for at least one cycle).
REQ-016 Full: if hp[c]+1 == tp, the ack SHALL be withheld until tp advances; no overwrite.
REQ-017 FSM states: IDLE, READ, COMPARE, VERIFY, FAULT.
REQ-018 IDLE -> READ when hp0 != tp and hp1 != tp (both cores have an uncompared entry); tp is driven on comp_tail_pointer*.
REQ-019 READ -> COMPARE after one cycle (RAM latency).
REQ-020 COMPARE: fprint0 == fprint1 -> tp += 1 and go to IDLE; otherwise go to FAULT.
REQ-021 IDLE -> VERIFY when no compare is pending and checkin_reg_out != 0; comp_task = lowest set bit index, latched on entry.
REQ-022 On entry to VERIFY, if hp0 != hp1 (unequal fingerprint counts), the block SHALL go to FAULT instead.
REQ-023 VERIFY: comp_task_verified SHALL be held high; on fprint_reg_ack go to IDLE the next cycle.
REQ-024 FAULT: on entry mismatch is set and mismatch_task is loaded with the task lowest-set in checkin_reg_out, or comp_task if unknown; hp0, hp1 and tp SHALL reset to 0 (discard); comp_task_verified SHALL be asserted for that task until fprint_reg_ack, then IDLE.
REQ-025 Compare has priority over VERIFY when both are eligible in IDLE.
REQ-026 Increments SHALL proceed in every state, concurrent with compare and verify.
REQ-027 mismatch_clear SHALL clear mismatch and mismatch_task the next cycle; a fault in the same cycle wins (flag stays set).
REQ-028 mismatch_task SHALL NOT be overwritten by later faults while mismatch is set.

Reset
REQ-029 Reset SHALL force IDLE, hp0 = hp1 = tp = 0, increment_hp_ack = 0, comp_task_verified = 0, comp_task = 0, mismatch = 0, mismatch_task = 0, asynchronously, including mid-VERIFY or mid-increment.

Structure
REQ-030 CRC_WIDTH, CRC_KEY_SIZE, CRC_KEY_WIDTH, CRC_RAM_SIZE and CRC_RAM_ADDRESS_WIDTH SHALL come from the shared crc_defines include; FSM state encodings stay local.
REQ-031 The lowest-set-bit priority encoder (CRC_KEY_SIZE -> CRC_KEY_WIDTH) SHALL be a sub-module, fprint_task_prio_enc.

Verification
REQ-032 Three increments per core with matching fprints 0xDEADBEEF, then checkin_reg_out = 0x0004 -> tp = 3, comp_task_verified with comp_task = 2 held until ack, mismatch = 0.
REQ-033 One increment per core, fprint0 = 0x1, fprint1 = 0x2 -> mismatch = 1, pointers reset to 0, comp_task_verified asserted; mismatch_clear -> mismatch = 0.
REQ-034 Core 0 increments CRC_RAM_SIZE times with core 1 idle -> the last ack is withheld (hp0 = CRC_RAM_SIZE-1); one core-1 increment plus compare releases it.
REQ-035 Two core-0 increments, one core-1 increment, checkin_reg_out = 0x0001 -> after the one compare, FAULT with mismatch_task = 0.
REQ-036 Reset asserted while comp_task_verified is high -> all outputs 0 immediately; no ack is needed to recover.
REQ-037 checkin_reg_out = 0x0A00 -> comp_task = 9; increment_head_pointer held high for 5 cycles -> exactly one increment and one ack.
